// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL manager for one 32-bit lane backed by a word-addressed RAM.
// Responses leave through a fixed-latency pipeline into a credit-guarded FIFO.
module tl_ul_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 16384,
    parameter int          LATENCY   = 2,
    parameter int          QDEPTH    = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_bits_opcode,
    input  logic [2:0]  a_bits_param,
    input  logic [3:0]  a_bits_size,
    input  logic [9:0]  a_bits_source,
    input  logic [31:0] a_bits_address,
    input  logic [3:0]  a_bits_mask,
    input  logic [31:0] a_bits_data,
    input  logic        a_bits_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_bits_opcode,
    output logic [1:0]  d_bits_param,
    output logic [3:0]  d_bits_size,
    output logic [9:0]  d_bits_source,
    output logic [2:0]  d_bits_sink,
    output logic        d_bits_denied,
    output logic [31:0] d_bits_data,
    output logic        d_bits_corrupt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [9:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } resp_t;

    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] cnt;
    logic          a_fire;
    logic          d_fire;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          is_get;
    logic          is_put;
    logic          misaligned;
    logic          denied;
    resp_t         resp_now;
    logic          push;
    resp_t         push_resp;
    resp_t         fifo_mem [QDEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] fcount;
    resp_t         head;
    logic          unused_bits;

    // Credits cover both pipeline and FIFO, so accepted requests can never stall downstream.
    assign a_ready = !reset && (cnt < CW'(QDEPTH));
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    always_comb begin
        offset = a_bits_address - BASE_ADDR;
        idx    = offset[AW+1:2];
        is_get = (a_bits_opcode == 3'd4);
        is_put = (a_bits_opcode == 3'd0) || (a_bits_opcode == 3'd1);
        case (a_bits_size)
            4'd1:    misaligned = a_bits_address[0];
            4'd2:    misaligned = (a_bits_address[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        denied = (a_bits_address < BASE_ADDR)
               || ({2'b00, offset[31:2]} >= 32'(DEPTH))
               || (a_bits_size > 4'd2)
               || misaligned
               || !(is_get || is_put)
               || (is_put && a_bits_corrupt);
        resp_now.opcode  = is_get ? 3'd1 : 3'd0;
        resp_now.size    = a_bits_size;
        resp_now.source  = a_bits_source;
        resp_now.denied  = denied;
        resp_now.data    = (is_get && !denied) ? mem[idx] : 32'd0;
        resp_now.corrupt = is_get && denied;
    end

    assign unused_bits = ^{a_bits_param, offset[1:0]};

    always @(posedge clock) begin
        if (a_fire && is_put && !denied) begin
            for (int b = 0; b < 4; b++) begin
                if (a_bits_mask[b]) mem[idx][8*b +: 8] <= a_bits_data[8*b +: 8];
            end
        end
    end

    // The FIFO write itself is the last latency stage, hence LATENCY-1 pipeline registers.
    if (LATENCY == 1) begin : g_direct
        assign push      = a_fire;
        assign push_resp = resp_now;
    end else begin : g_pipe
        logic [LATENCY-2:0] stage_v;
        resp_t              stage_r [LATENCY-1];

        always_ff @(posedge clock) begin
            if (reset) begin
                stage_v <= '0;
            end else begin
                stage_v[0] <= a_fire;
                for (int k = 1; k < LATENCY - 1; k++) stage_v[k] <= stage_v[k-1];
            end
        end

        always_ff @(posedge clock) begin
            stage_r[0] <= resp_now;
            for (int k = 1; k < LATENCY - 1; k++) stage_r[k] <= stage_r[k-1];
        end

        assign push      = stage_v[LATENCY-2];
        assign push_resp = stage_r[LATENCY-2];
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            fcount <= '0;
            cnt    <= '0;
        end else begin
            if (push) wptr <= ptr_next(wptr);
            if (d_fire) rptr <= ptr_next(rptr);
            fcount <= fcount + CW'(push) - CW'(d_fire);
            cnt    <= cnt + CW'(a_fire) - CW'(d_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wptr] <= push_resp;
    end

    assign head           = fifo_mem[rptr];
    assign d_valid        = (fcount != '0);
    assign d_bits_opcode  = head.opcode;
    assign d_bits_param   = 2'd0;
    assign d_bits_size    = head.size;
    assign d_bits_source  = head.source;
    assign d_bits_sink    = 3'd0;
    assign d_bits_denied  = head.denied;
    assign d_bits_data    = head.data;
    assign d_bits_corrupt = head.corrupt;

    always @(posedge clock) begin
        if (!reset) begin
            assert (!(push && !d_fire && fcount == CW'(QDEPTH)));
            assert (!(d_fire && fcount == '0));
            assert (cnt <= CW'(QDEPTH));
            if (d_valid) assert (!$isunknown(head));
        end
    end

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Randomized bench for tl_ul_mem_responder against a queue/array model of the TL-UL rules.
module tb_tl_ul_mem_responder;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          DEPTH   = 16384;
    localparam int          LATENCY = 2;
    localparam int          QDEPTH  = 4;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic [9:0]  source;
        logic [2:0]  sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_bits_opcode;
    logic [2:0]  a_bits_param;
    logic [3:0]  a_bits_size;
    logic [9:0]  a_bits_source;
    logic [31:0] a_bits_address;
    logic [3:0]  a_bits_mask;
    logic [31:0] a_bits_data;
    logic        a_bits_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_param;
    logic [3:0]  d_bits_size;
    logic [9:0]  d_bits_source;
    logic [2:0]  d_bits_sink;
    logic        d_bits_denied;
    logic [31:0] d_bits_data;
    logic        d_bits_corrupt;

    logic [31:0] ref_mem [int];
    resp_t       exp_q [$];
    int          outstanding = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic  af, df, aro, are, dv;
    resp_t obs, expv;

    always #5 clock = ~clock;

    tl_ul_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH), .INIT_FILE("")
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param), .a_bits_size(a_bits_size),
        .a_bits_source(a_bits_source), .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask),
        .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param), .d_bits_size(d_bits_size),
        .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink), .d_bits_denied(d_bits_denied),
        .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt)
    );

    // Reference: applies a request to the word array and returns the response it must produce.
    function automatic resp_t model_req(input logic [2:0] op, input logic [3:0] sz, input logic [9:0] src,
                                        input logic [31:0] addr, input logic [3:0] mask,
                                        input logic [31:0] data, input logic cor);
        longint off;
        int     widx;
        bit     get, put, den;
        logic [31:0] w;
        resp_t  r;
        off  = longint'(addr) - longint'(BASE);
        get  = (op == 3'd4);
        put  = (op == 3'd0) || (op == 3'd1);
        den  = (off < 0) || (off >= longint'(DEPTH) * 4) || (sz > 4'd2);
        if (!den && (addr % (32'd1 << sz)) != 0) den = 1'b1;
        if (!(get || put) || (put && cor)) den = 1'b1;
        widx = int'(off / 4);
        if (put && !den) begin
            w = ref_mem.exists(widx) ? ref_mem[widx] : 32'd0;
            for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[widx] = w;
        end
        r.opcode  = get ? 3'd1 : 3'd0;
        r.param   = 2'd0;
        r.size    = sz;
        r.source  = src;
        r.sink    = 3'd0;
        r.denied  = den;
        r.data    = (get && !den) ? ref_mem[widx] : 32'd0;
        r.corrupt = get && den;
        return r;
    endfunction

    task automatic set_a(input logic [2:0] op, input logic [3:0] sz, input logic [9:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input logic cor);
        a_valid        = 1'b1;
        a_bits_opcode  = op;
        a_bits_param   = 3'($urandom);
        a_bits_size    = sz;
        a_bits_source  = src;
        a_bits_address = addr;
        a_bits_mask    = mask;
        a_bits_data    = data;
        a_bits_corrupt = cor;
    endtask

    task automatic idle();
        a_valid = 1'b0;
    endtask

    task automatic random_req(input logic [9:0] src);
        int          w;
        int          k;
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [31:0] boff;
        w    = $urandom_range(0, 31);
        k    = $urandom_range(0, 9);
        op   = (k < 4) ? 3'd4 : (k < 7) ? 3'd0 : (k < 9) ? 3'd1 : 3'($urandom_range(2, 7));
        sz   = ($urandom_range(0, 9) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
        boff = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd0;
        set_a(op, sz, src, BASE + 32'(w * 4) + boff, 4'($urandom), $urandom, $urandom_range(0, 7) == 0);
    endtask

    // Samples at the falling edge, advances the model by one clock, then returns just after the rising edge.
    task automatic cycle();
        @(negedge clock);
        aro  = a_ready;
        are  = !reset && (outstanding < QDEPTH);
        dv   = d_valid;
        obs  = {d_bits_opcode, d_bits_param, d_bits_size, d_bits_source, d_bits_sink,
                d_bits_denied, d_bits_data, d_bits_corrupt};
        af   = a_valid && a_ready;
        df   = d_valid && d_ready;
        expv = '1;
        if (reset) begin
            exp_q.delete();
            outstanding = 0;
        end else begin
            if (df) begin
                if (exp_q.size() > 0) expv = exp_q.pop_front();
                outstanding--;
            end
            if (af) begin
                exp_q.push_back(model_req(a_bits_opcode, a_bits_size, a_bits_source, a_bits_address,
                                          a_bits_mask, a_bits_data, a_bits_corrupt));
                outstanding++;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        d_ready = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if (aro !== 1'b0) $display("[TB] FAIL reset_a_ready: got %b expected 0", aro); else n_pass++;
        n_checks++;
        if (dv !== 1'b0) $display("[TB] FAIL reset_d_valid: got %b expected 0", dv); else n_pass++;
        reset   = 1'b0;
        d_ready = 1'b1;
        cycle();
        n_checks++;
        if (aro !== 1'b1) $display("[TB] FAIL post_reset_a_ready: got %b expected 1", aro); else n_pass++;
        n_checks++;
        if (dv !== 1'b0) $display("[TB] FAIL post_reset_d_valid: got %b expected 0", dv); else n_pass++;
    endtask

    task automatic test_preload();
        int nacc = 0;
        d_ready = 1'b1;
        for (int w = 0; w < 32; w++) begin
            set_a(3'd0, 4'd2, 10'(w), BASE + 32'(w * 4), 4'hF, (w == 4) ? 32'hDEADBEEF : $urandom, 1'b0);
            cycle();
            if (af) nacc++;
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL preload_resp: got %h expected %h", obs, expv); else n_pass++;
            end
        end
        idle();
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            cycle();
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL preload_resp: got %h expected %h", obs, expv); else n_pass++;
            end
        end
        n_checks++;
        if (nacc !== 32) $display("[TB] FAIL preload_accepts: got %0d expected 32", nacc); else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("[TB] FAIL preload_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_get_latency();
        int c0, c1;
        int lat = -1;
        d_ready = 1'b1;
        set_a(3'd4, 4'd2, 10'h3A, BASE + 32'h10, 4'hF, 32'd0, 1'b0);
        c0 = cyc;
        cycle();
        n_checks++;
        if (af !== 1'b1) $display("[TB] FAIL get_accept: got %b expected 1", af); else n_pass++;
        idle();
        for (int t = 0; t < 10 && lat < 0; t++) begin
            c1 = cyc;
            cycle();
            if (dv) begin
                lat = c1 - c0;
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL get_resp: got %h expected %h", obs, expv); else n_pass++;
                n_checks++;
                if ({obs.opcode, obs.source, obs.denied, obs.data} !== {3'd1, 10'h3A, 1'b0, 32'hDEADBEEF})
                    $display("[TB] FAIL get_fields: got op=%0d src=%h den=%b data=%h expected op=1 src=3a den=0 data=deadbeef",
                             obs.opcode, obs.source, obs.denied, obs.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (lat !== LATENCY) $display("[TB] FAIL get_latency: got %0d expected %0d", lat, LATENCY); else n_pass++;
    endtask

    task automatic test_partial_raw();
        resp_t got [$];
        d_ready = 1'b1;
        set_a(3'd1, 4'd2, 10'h21, BASE + 32'h10, 4'b0101, 32'h11223344, 1'b0);
        cycle();
        set_a(3'd4, 4'd2, 10'h22, BASE + 32'h10, 4'hF, 32'd0, 1'b0);
        cycle();
        idle();
        for (int t = 0; t < 10 && got.size() < 2; t++) begin
            cycle();
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL raw_resp: got %h expected %h", obs, expv); else n_pass++;
                got.push_back(obs);
            end
        end
        n_checks++;
        if (got.size() !== 2) $display("[TB] FAIL raw_count: got %0d expected 2", got.size()); else n_pass++;
        if (got.size() == 2) begin
            n_checks++;
            if ({got[0].opcode, got[0].data, got[1].opcode, got[1].data} !== {3'd0, 32'd0, 3'd1, 32'hDE22BE44})
                $display("[TB] FAIL raw_order: got %0d/%h then %0d/%h expected 0/00000000 then 1/de22be44",
                         got[0].opcode, got[0].data, got[1].opcode, got[1].data);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int  i = 0;
        int  ndone = 0;
        bit  seen_first = 0;
        bit  check_next = 0;
        d_ready = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (i < 6) set_a(3'd4, 4'd2, 10'(10'h100 + i), BASE + 32'(i * 4), 4'hF, 32'd0, 1'b0);
            else idle();
            cycle();
            if (af) i++;
        end
        n_checks++;
        if (i !== QDEPTH) $display("[TB] FAIL bp_accepts: got %0d expected %0d", i, QDEPTH); else n_pass++;
        n_checks++;
        if (aro !== 1'b0) $display("[TB] FAIL bp_a_ready_low: got %b expected 0", aro); else n_pass++;
        d_ready = 1'b1;
        for (int t = 0; t < 30 && ndone < 6; t++) begin
            if (i < 6) set_a(3'd4, 4'd2, 10'(10'h100 + i), BASE + 32'(i * 4), 4'hF, 32'd0, 1'b0);
            else idle();
            cycle();
            if (check_next) begin
                check_next = 0;
                n_checks++;
                if (aro !== 1'b1) $display("[TB] FAIL bp_a_ready_return: got %b expected 1", aro); else n_pass++;
            end
            if (af) i++;
            if (df) begin
                if (!seen_first) begin
                    seen_first = 1;
                    check_next = 1;
                    n_checks++;
                    if (aro !== 1'b0) $display("[TB] FAIL bp_a_ready_first_fire: got %b expected 0", aro); else n_pass++;
                end
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL bp_resp: got %h expected %h", obs, expv); else n_pass++;
                n_checks++;
                if (obs.source !== 10'(10'h100 + ndone))
                    $display("[TB] FAIL bp_order: got %h expected %h", obs.source, 10'(10'h100 + ndone));
                else n_pass++;
                ndone++;
            end
        end
        idle();
        n_checks++;
        if (ndone !== 6) $display("[TB] FAIL bp_count: got %0d expected 6", ndone); else n_pass++;
    endtask

    task automatic test_denied();
        logic [2:0]  ops   [9] = '{3'd4, 3'd4, 3'd4, 3'd3, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4};
        logic [3:0]  sizes [9] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd3};
        logic [31:0] addrs [9] = '{BASE - 32'd4, BASE + 32'(DEPTH * 4), BASE + 32'd2, BASE + 32'h20,
                                   BASE + 32'h24, BASE + 32'h20, BASE + 32'h24, BASE + 32'd1, BASE};
        logic        cors  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        dens  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int i = 0;
        int k = 0;
        d_ready = 1'b1;
        for (int t = 0; t < 40 && k < 9; t++) begin
            if (i < 9) set_a(ops[i], sizes[i], 10'(10'h200 + i), addrs[i], 4'hF, $urandom, cors[i]);
            else idle();
            cycle();
            if (af) i++;
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL denied_resp: got %h expected %h", obs, expv); else n_pass++;
                n_checks++;
                if (obs.denied !== dens[k])
                    $display("[TB] FAIL denied_flag_%0d: got %b expected %b", k, obs.denied, dens[k]);
                else n_pass++;
                k++;
            end
        end
        idle();
        n_checks++;
        if (k !== 9) $display("[TB] FAIL denied_count: got %0d expected 9", k); else n_pass++;
    endtask

    task automatic test_stream();
        int nacc = 0;
        d_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            random_req(10'(n));
            cycle();
            if (af) nacc++;
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL stream_resp: got %h expected %h", obs, expv); else n_pass++;
            end
        end
        idle();
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            cycle();
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL stream_resp: got %h expected %h", obs, expv); else n_pass++;
            end
        end
        n_checks++;
        if (nacc !== 100) $display("[TB] FAIL stream_throughput: got %0d accepts expected 100", nacc); else n_pass++;
    endtask

    task automatic test_random_backpressure();
        bit pending = 0;
        int src = 0;
        for (int t = 0; t < 300; t++) begin
            if (!pending && $urandom_range(0, 9) < 7) begin
                random_req(10'(src));
                src++;
                pending = 1;
            end
            d_ready = 1'($urandom_range(0, 1));
            cycle();
            n_checks++;
            if (aro !== are) $display("[TB] FAIL rbp_a_ready: got %b expected %b", aro, are); else n_pass++;
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL rbp_resp: got %h expected %h", obs, expv); else n_pass++;
            end
            if (af) begin
                pending = 0;
                idle();
            end
        end
        idle();
        d_ready = 1'b1;
        for (int t = 0; t < 30 && exp_q.size() > 0; t++) begin
            cycle();
            if (df) begin
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL rbp_resp: got %h expected %h", obs, expv); else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() !== 0) $display("[TB] FAIL rbp_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd = $urandom;
        bit any_dv = 0;
        int nresp = 0;
        d_ready = 1'b0;
        set_a(3'd0, 4'd2, 10'h3F0, BASE + 32'h1C, 4'hF, wd, 1'b0);
        cycle();
        for (int g = 1; g <= 3; g++) begin
            set_a(3'd4, 4'd2, 10'(10'h3F0 + g), BASE + 32'(g * 4), 4'hF, 32'd0, 1'b0);
            cycle();
        end
        idle();
        reset = 1'b1;
        cycle();
        n_checks++;
        if (aro !== 1'b0) $display("[TB] FAIL mid_reset_a_ready: got %b expected 0", aro); else n_pass++;
        reset = 1'b0;
        cycle();
        n_checks++;
        if (dv !== 1'b0) $display("[TB] FAIL mid_reset_d_valid: got %b expected 0", dv); else n_pass++;
        n_checks++;
        if (aro !== 1'b1) $display("[TB] FAIL mid_reset_credit: got %b expected 1", aro); else n_pass++;
        for (int t = 0; t < 5; t++) begin
            cycle();
            if (dv) any_dv = 1;
        end
        n_checks++;
        if (any_dv !== 1'b0) $display("[TB] FAIL mid_reset_flush: got d_valid %b expected 0", any_dv); else n_pass++;
        d_ready = 1'b1;
        set_a(3'd4, 4'd2, 10'h3FF, BASE + 32'h1C, 4'hF, 32'd0, 1'b0);
        cycle();
        idle();
        for (int t = 0; t < 10 && nresp < 1; t++) begin
            cycle();
            if (df) begin
                nresp++;
                n_checks++;
                if (obs !== expv) $display("[TB] FAIL mid_reset_resp: got %h expected %h", obs, expv); else n_pass++;
                n_checks++;
                if (obs.data !== wd) $display("[TB] FAIL mid_reset_put_kept: got %h expected %h", obs.data, wd); else n_pass++;
            end
        end
        n_checks++;
        if (nresp !== 1) $display("[TB] FAIL mid_reset_count: got %0d expected 1", nresp); else n_pass++;
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        a_valid        = 1'b0;
        a_bits_opcode  = 3'd0;
        a_bits_param   = 3'd0;
        a_bits_size    = 4'd0;
        a_bits_source  = 10'd0;
        a_bits_address = 32'd0;
        a_bits_mask    = 4'd0;
        a_bits_data    = 32'd0;
        a_bits_corrupt = 1'b0;
        d_ready        = 1'b0;
        test_reset();
        test_preload();
        test_get_latency();
        test_partial_raw();
        test_backpressure();
        test_denied();
        test_stream();
        test_random_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
